// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one external full-adder cell over WIDTH clocks, LSB first.
// Optional subtract mode (input port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;

  logic             sub_w;
  logic [WIDTH-1:0] b_load_d, sum_shift_d;
  logic             carry_load_d;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so the invert and forced carry happen at capture.
  assign b_load_d     = sub_w ? ~b : b;
  assign carry_load_d = sub_w ? 1'b1 : cin;

  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift_d = fa_sum;
    end else begin : g_sum_wn
      assign sum_shift_d = {fa_sum, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b_load_d;
            carry_q <= carry_load_d;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sum_q   <= sum_shift_d;
          carry_q <= fa_cout;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q  <= fa_cout;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // FA drive comes only from registers, gated so the cell sees zeros outside SHIFT.
  assign fa_a   = (state_q == SHIFT) & a_sh_q[0];
  assign fa_b   = (state_q == SHIFT) & b_sh_q[0];
  assign fa_cin = (state_q == SHIFT) & carry_q;

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: external FA modelled by assigns, arithmetic reference model and result scoreboard.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             cin = 1'b0, sub = 1'b0;
  logic             fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  // Clock / external full adder
  always #5 clk = ~clk;
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an operation is busy for WIDTH+1 cycles after acceptance.
  logic [WIDTH:0]   exp_q[$];
  int               remain = 0;
  int               acc_cnt = 0;
  logic [WIDTH-1:0] m_a = '0, m_beff = '0;
  logic             m_c0 = 1'b0;
  logic [WIDTH:0]   last_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain = 0;
      exp_q.delete();
      last_res = '0;
    end else if (remain > 0) begin
      remain--;
    end else if (start) begin
      m_a    = a;
      m_beff = (SUB_EN && sub) ? ~b : b;
      m_c0   = (SUB_EN && sub) ? 1'b1 : cin;
      exp_q.push_back({1'b0, m_a} + {1'b0, m_beff} + {{WIDTH{1'b0}}, m_c0});
      remain = WIDTH + 1;
      acc_cnt++;
    end
  end

  function automatic logic carry_into(input int j);
    longint mask;
    longint s;
    mask = (64'd1 << j) - 1;
    s = (longint'(m_a) & mask) + (longint'(m_beff) & mask) + longint'(m_c0);
    return s[j];
  endfunction

  // Monitor: per-cycle protocol/FA checks and scoreboard pop on done.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, remain > 0);
      chk("done", done, remain == 1);
      if (remain > 1) begin
        int j;
        j = WIDTH + 1 - remain;
        chk("fa_a_shift", fa_a, m_a[j]);
        chk("fa_b_shift", fa_b, m_beff[j]);
        chk("fa_cin_shift", fa_cin, carry_into(j));
      end else begin
        chk("fa_idle", {fa_a, fa_b, fa_cin}, 0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          chk("result", {cout, sum}, e);
          last_res = e;
        end
      end else if (remain == 0) begin
        chk("result_hold", {cout, sum}, last_res);
      end
    end
  end

  // Driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    while (remain != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", remain != 0, 0);
  endtask

  task automatic op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                    input logic tc, input logic ts);
    @(negedge clk);
    wait_idle();
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic op_check(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tc, input logic ts, input logic [WIDTH:0] req);
    op(ta, tb_v, tc, ts);
    wait_idle();
    chk(nm, {cout, sum}, req);
  endtask

  initial begin
    int n;
    int base;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, fa_a, fa_b, fa_cin, cout, sum}, 0);
    rst_n = 1'b1;

    // Directed arithmetic
    op_check("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096);
    op_check("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
    op_check("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);

    // Start held high: second pair accepted only at the first IDLE edge
    @(negedge clk);
    wait_idle();
    base = acc_cnt;
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    n = 0;
    while (acc_cnt != base + 1 && n < 50) begin @(negedge clk); n++; end
    a = 8'h10; b = 8'h20;
    n = 0;
    while (acc_cnt != base + 2 && n < 50) begin @(negedge clk); n++; end
    chk("b2b_accepts", acc_cnt - base, 2);
    start = 1'b0;
    wait_idle();
    chk("b2b_second", {cout, sum}, 9'h030);

    // Reset during SHIFT after three shift edges
    op(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, fa_a, fa_b, fa_cin, cout, sum}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op_check("after_abort", 8'h01, 8'h01, 1'b0, 1'b0, 9'h002);

`ifdef SERIAL_ADD_SUB_EN
    op_check("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 9'h10F);
    op_check("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF);
`endif

    // Random operations with stray start pulses while busy
    for (int i = 0; i < 40; i++) begin
      op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, WIDTH)) @(negedge clk);
        if (remain > 0) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
